pe_output_writer: RTL and testbench
===================================

Name: pe_output_writer

Overview:
- Drains finished output groups from the PE2 output shift register into the output feature-map memory.
- Each PE2 group-done pulse (counter4 carry) captures the 4-lane x 8-bit shift register contents into a small FIFO.
- The FIFO is drained as packed 32-bit words over a write handshake with a stallable memory port.
- Sits between PE2 and the output SRAM, and reports frame completion and capture overflow to the top-level controller.

Parameters:
- DATA_W, 8, bits per lane (matches shift register width)
- LANES, 4, lanes per captured group
- ADDR_W, 10, output memory word-address width
- FIFO_DEPTH, 4, capture FIFO entries (power of two, >=2)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; latches baseAddr/numWords, begins frame
- baseAddr  input  ADDR_W  first write address
- numWords  input  ADDR_W  words in frame (0 = no writes, immediate done)
- groupDone  input  1  capture strobe (PE2 cout3)
- shiftRegIn  input  DATA_W x [0:LANES-1]  PE2 shiftRegOut
- wrReady  input  1  memory accepts write this cycle
- wrValid  output  1  write request
- wrAddr  output  ADDR_W  write address
- wrData  output  DATA_W*LANES  packed word, lane 0 in bits [7:0]
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when the last word is accepted
- overflow  output  1  sticky: capture attempted while FIFO full

Behaviour:
- Reset (rst=0 at clk edge): FSM=IDLE; FIFO empty; counters cleared; wrValid=0, wrAddr=0, wrData=0, busy=0, done=0, overflow=0. Reset mid-frame aborts the frame; no further writes are issued.
- FSM states:
  - IDLE: start -> RUN, or -> FINISH if numWords==0.
  - RUN: captures groups and issues writes; when the accepted count reaches numWords -> FINISH.
  - FINISH: done=1 for one cycle -> IDLE.
- busy=1 in RUN and FINISH.
- start outside IDLE is ignored.
- Capture: in RUN, groupDone=1 and FIFO not full -> push {lane3,lane2,lane1,lane0} the same cycle.
- groupDone in IDLE/FINISH is ignored.
- groupDone in RUN with FIFO full: data is dropped and overflow is set. overflow clears only on reset or on the next start.
- Captures beyond numWords in a frame are also dropped and do NOT set overflow. The frame counts captured groups separately from accepted writes.
- Write port:
  - wrValid=1 whenever the FIFO is non-empty in RUN.
  - wrData = FIFO head (registered output, no combinational path from shiftRegIn).
  - Minimum latency groupDone -> wrValid is 1 cycle.
- Handshake:
  - Transfer occurs when wrValid && wrReady: pop FIFO, wrAddr increments, accepted count increments.
  - While wrValid=1 && wrReady=0, wrAddr and wrData hold stable.
  - wrValid is never deasserted before acceptance.
- Push and pop in the same cycle: occupancy unchanged. This is legal when full (pop frees the slot first, so no overflow).
- Address: wrAddr = baseAddr + acceptedCount, modulo 2^ADDR_W (wraps silently).
- The last acceptance (acceptedCount becomes numWords) moves the FSM to FINISH the next cycle. done pulses in that FINISH cycle; wrValid=0.

Decomposition:
- Shared package (cnn_pkg):
  - DATA_W, LANES, ADDR_W constants.
  - lane_t typedef = logic [DATA_W-1:0].
  - word_t typedef = logic [DATA_W*LANES-1:0].
  - writer_state_t enum {IDLE, RUN, FINISH}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty, registered head output).

Test Plan:
- Basic frame:
  - Stimulus: start, baseAddr=0x010, numWords=2, wrReady=1; groupDone with lanes {0x11,0x22,0x33,0x44} then {0x55,0x66,0x77,0x88}.
  - Response: writes 0x44332211@0x010 and 0x88776655@0x011, then done pulse, busy falls.
- Stall:
  - Stimulus: wrReady=0 for 5 cycles after the first capture.
  - Response: wrValid stays 1, wrAddr/wrData unchanged; the write completes one cycle after wrReady=1.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, wrReady=0, 5 groupDone pulses.
  - Response: overflow=1 after the 5th; then wrReady=1 yields exactly 4 writes in order.
- Zero/wrap:
  - Stimulus 1: numWords=0 -> done one cycle after start, no wrValid.
  - Stimulus 2: baseAddr=0x3FF, numWords=2 -> addresses 0x3FF then 0x000.
- Reset mid-frame:
  - Stimulus: rst=0 for one edge after 1 of 3 words is written.
  - Response: all outputs 0, FSM IDLE; a new start runs cleanly.
- Simultaneous push/pop:
  - Stimulus: FIFO full, groupDone and wrReady=1 in the same cycle.
  - Response: no overflow, occupancy stays full, data order preserved.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, data types and writer FSM states for the CNN datapath
package cnn_pkg;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int ADDR_W = 10;

  typedef logic [DATA_W-1:0]       lane_t;
  typedef logic [DATA_W*LANES-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } writer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered head word and synchronous clear
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // dout always mirrors the oldest entry; a lone entry being replaced comes straight from din
      if (pop) begin
        if (count > (AW+1)'(1)) begin
          dout <= mem[rd_next];
        end else if (push) begin
          dout <= din;
        end
      end else if (push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/pe_output_writer.sv
// rtl/pe_output_writer.sv - captures PE2 output groups and drains them as packed words to output memory
module pe_output_writer #(
  parameter int DATA_W     = cnn_pkg::DATA_W,
  parameter int LANES      = cnn_pkg::LANES,
  parameter int ADDR_W     = cnn_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       baseAddr,
  input  logic [ADDR_W-1:0]       numWords,
  input  logic                    groupDone,
  input  logic [DATA_W-1:0]       shiftRegIn [0:LANES-1],
  input  logic                    wrReady,
  output logic                    wrValid,
  output logic [ADDR_W-1:0]       wrAddr,
  output logic [DATA_W*LANES-1:0] wrData,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  import cnn_pkg::*;

  writer_state_t state;
  writer_state_t state_next;

  logic [ADDR_W-1:0]       num_q;
  logic [ADDR_W-1:0]       accepted_q;
  logic [ADDR_W-1:0]       captured_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    ovf_q;
  logic [DATA_W*LANES-1:0] packed_in;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    start_ok;
  logic                    accept;
  logic                    capture;
  logic                    push;

  always_comb begin
    packed_in = '0;
    for (int i = 0; i < LANES; i++) begin
      packed_in[i*DATA_W +: DATA_W] = shiftRegIn[i];
    end
  end

  assign start_ok = start && (state == IDLE);
  assign wrValid  = (state == RUN) && !fifo_empty;
  assign accept   = wrValid && wrReady;
  // groups past the frame length are silently discarded; only a full FIFO counts as overflow
  assign capture  = (state == RUN) && groupDone && (captured_q < num_q);
  assign push     = capture && (!fifo_full || accept);

  sync_fifo #(
    .WIDTH (DATA_W*LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .push  (push),
    .pop   (accept),
    .din   (packed_in),
    .dout  (wrData),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (numWords == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (accept && (accepted_q + 1'b1 == num_q)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      num_q      <= '0;
      accepted_q <= '0;
      captured_q <= '0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        num_q      <= numWords;
        addr_q     <= baseAddr;
        accepted_q <= '0;
        captured_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (push) begin
          captured_q <= captured_q + 1'b1;
        end
        if (accept) begin
          accepted_q <= accepted_q + 1'b1;
          addr_q     <= addr_q + 1'b1;
        end
        if (capture && fifo_full && !accept) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign wrAddr   = addr_q;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pe_output_writer.sv
// tb/tb_pe_output_writer.sv - directed self-checking bench for pe_output_writer
module tb_pe_output_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  baseAddr;
  logic [9:0]  numWords;
  logic        groupDone;
  logic [7:0]  lanes [0:3];
  logic        wrReady;
  logic        wrValid;
  logic [9:0]  wrAddr;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  pe_output_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .baseAddr   (baseAddr),
    .numWords   (numWords),
    .groupDone  (groupDone),
    .shiftRegIn (lanes),
    .wrReady    (wrReady),
    .wrValid    (wrValid),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) lanes[i] = w[i*8 +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_frame(input logic [9:0] base, input logic [9:0] num, input logic rdy);
    baseAddr = base;
    numWords = num;
    wrReady  = rdy;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    logic [7:0] kb;
    rst = 1'b0; start = 1'b0; baseAddr = '0; numWords = '0;
    groupDone = 1'b0; wrReady = 1'b0; set_word(32'h0);
    tick(); tick();
    rst = 1'b1;
    check("rst_valid", wrValid, 0);
    check("rst_addr", wrAddr, 0);
    check("rst_data", wrData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);

    // basic two-word frame
    begin_frame(10'h010, 10'd2, 1'b1);
    check("basic_busy", busy, 1);
    check("basic_novalid", wrValid, 0);
    set_word(32'h44332211); groupDone = 1'b1; tick();
    check("basic_v0", wrValid, 1);
    check("basic_d0", wrData, 32'h44332211);
    check("basic_a0", wrAddr, 32'h010);
    set_word(32'h88776655); tick();
    groupDone = 1'b0;
    check("basic_v1", wrValid, 1);
    check("basic_d1", wrData, 32'h88776655);
    check("basic_a1", wrAddr, 32'h011);
    tick();
    check("basic_done", done, 1);
    check("basic_fin_valid", wrValid, 0);
    check("basic_fin_busy", busy, 1);
    tick();
    check("basic_done_clr", done, 0);
    check("basic_idle", busy, 0);

    // stall
    begin_frame(10'h100, 10'd2, 1'b0);
    set_word(32'h04030201); groupDone = 1'b1; tick();
    groupDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", wrValid, 1);
      check("stall_data", wrData, 32'h04030201);
      check("stall_addr", wrAddr, 32'h100);
      if (i < 4) tick();
    end
    wrReady = 1'b1; tick();
    check("stall_accepted", wrValid, 0);
    check("stall_addr_inc", wrAddr, 32'h101);
    set_word(32'hD4C3B2A1); groupDone = 1'b1; tick();
    groupDone = 1'b0;
    check("stall_d1", wrData, 32'hD4C3B2A1);
    check("stall_a1", wrAddr, 32'h101);
    tick();
    check("stall_done", done, 1);
    tick();

    // overflow with four-entry FIFO
    begin_frame(10'h200, 10'd6, 1'b0);
    groupDone = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      kb = 8'(k);
      set_word({kb, kb, kb, kb});
      tick();
      if (k == 4) check("ovf_before", overflow, 0);
    end
    groupDone = 1'b0;
    check("ovf_set", overflow, 1);
    wrReady = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      kb = 8'(j);
      check("ovf_drain_valid", wrValid, 1);
      check("ovf_drain_data", wrData, {kb, kb, kb, kb});
      check("ovf_drain_addr", wrAddr, 32'h200 + j - 1);
      tick();
    end
    check("ovf_empty", wrValid, 0);
    check("ovf_sticky", overflow, 1);
    set_word(32'h06060606); groupDone = 1'b1; tick();
    check("ovf_d5", wrData, 32'h06060606);
    check("ovf_a5", wrAddr, 32'h204);
    set_word(32'h07070707); tick();
    groupDone = 1'b0;
    check("ovf_d6", wrData, 32'h07070707);
    check("ovf_a6", wrAddr, 32'h205);
    tick();
    check("ovf_done", done, 1);
    tick();
    check("ovf_idle_sticky", overflow, 1);

    // zero-length frame
    begin_frame(10'h055, 10'd0, 1'b1);
    check("zero_done", done, 1);
    check("zero_valid", wrValid, 0);
    check("zero_busy", busy, 1);
    check("zero_ovf_clr", overflow, 0);
    tick();
    check("zero_done_clr", done, 0);
    check("zero_idle", busy, 0);

    // address wrap
    begin_frame(10'h3FF, 10'd2, 1'b1);
    set_word(32'hCAFEBABE); groupDone = 1'b1; tick();
    check("wrap_d0", wrData, 32'hCAFEBABE);
    check("wrap_a0", wrAddr, 32'h3FF);
    set_word(32'h12345678); tick();
    groupDone = 1'b0;
    check("wrap_d1", wrData, 32'h12345678);
    check("wrap_a1", wrAddr, 32'h000);
    tick();
    check("wrap_done", done, 1);
    tick();

    // reset mid-frame
    begin_frame(10'h020, 10'd3, 1'b1);
    set_word(32'h0A0B0C0D); groupDone = 1'b1; tick();
    check("mid_v0", wrValid, 1);
    check("mid_d0", wrData, 32'h0A0B0C0D);
    set_word(32'h01020304); tick();
    groupDone = 1'b0;
    check("mid_a1", wrAddr, 32'h021);
    check("mid_v1", wrValid, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    check("mid_rst_valid", wrValid, 0);
    check("mid_rst_addr", wrAddr, 0);
    check("mid_rst_data", wrData, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", overflow, 0);
    groupDone = 1'b1; tick(); groupDone = 1'b0;
    check("idle_capture_ignored", wrValid, 0);
    begin_frame(10'h030, 10'd1, 1'b1);
    set_word(32'h99887766); groupDone = 1'b1; tick();
    groupDone = 1'b0;
    check("restart_d", wrData, 32'h99887766);
    check("restart_a", wrAddr, 32'h030);
    tick();
    check("restart_done", done, 1);
    tick();
    check("restart_idle", busy, 0);

    // simultaneous push/pop while full
    begin_frame(10'h040, 10'd6, 1'b0);
    groupDone = 1'b1;
    for (int k = 8'h21; k <= 8'h24; k++) begin
      kb = 8'(k);
      set_word({kb, kb, kb, kb});
      tick();
    end
    set_word(32'h25252525); wrReady = 1'b1; tick();
    check("pp_no_ovf", overflow, 0);
    check("pp_head", wrData, 32'h22222222);
    check("pp_addr", wrAddr, 32'h041);
    set_word(32'h26262626); wrReady = 1'b0; tick();
    groupDone = 1'b0;
    check("pp_still_full", overflow, 1);
    wrReady = 1'b1;
    for (int k = 8'h22; k <= 8'h25; k++) begin
      kb = 8'(k);
      check("pp_order_data", wrData, {kb, kb, kb, kb});
      check("pp_order_addr", wrAddr, 32'h041 + k - 8'h22);
      tick();
    end
    check("pp_drained", wrValid, 0);
    set_word(32'h27272727); groupDone = 1'b1; tick();
    groupDone = 1'b0;
    check("pp_last_d", wrData, 32'h27272727);
    check("pp_last_a", wrAddr, 32'h045);
    tick();
    check("pp_done", done, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
